exec_unit: RTL and testbench

Sequenced execution stage directly downstream of the 8×16 register file. On a `start` request it:
- reads two source registers through the file's single read port, one per cycle;
- passes the second operand through a 1-bit shifter and an ALU;
- latches the result and status flags;
- writes the result back through the file's write port, then signals `done`.

It is the consumer of the register file's `data_out` and the producer of its `data_in`/`writenum`/`write`.

---
 rtl/exec_unit.sv | 172 +++++++++++++++++
 tb/tb_exec_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Sequenced read-read-execute-writeback stage for an 8x16 register file.
// Optional macro EXEC_UNIT_SAMEREG_EN: skip the second read when both sources match.
module exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       rd_a,
    input  logic [2:0]       rd_b,
    input  logic [2:0]       rd_dst,
    input  logic [1:0]       shift,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] reg_data,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic [WIDTH-1:0] wb_data,
    output logic             busy,
    output logic             done,
    output logic             z,
    output logic             n,
    output logic             v
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       rd_a_q, rd_b_q, rd_dst_q;
    logic [1:0]       shift_q, op_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic             z_q, n_q, v_q;

    logic [WIDTH-1:0] b_shifted;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             same_src;

    assign same_src = (rd_a_q == rd_b_q);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RDA;
`ifdef EXEC_UNIT_SAMEREG_EN
            S_RDA:  state_d = same_src ? S_EXEC : S_RDB;
`else
            S_RDA:  state_d = S_RDB;
`endif
            S_RDB:  state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        readnum = 3'd0;
        write   = 1'b0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_RDA: readnum = rd_a_q;
            S_RDB: readnum = rd_b_q;
            S_WB: begin
                write = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign writenum = rd_dst_q;
    assign wb_data  = c_q;
    assign z        = z_q;
    assign n        = n_q;
    assign v        = v_q;

    always_comb begin
        b_shifted = b_q;
        case (shift_q)
            2'b01: b_shifted = {b_q[WIDTH-2:0], 1'b0};
            2'b10: b_shifted = {1'b0, b_q[WIDTH-1:1]};
            2'b11: b_shifted = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: ;
        endcase
    end

    // Overflow: operands of the effective sign agree but the result sign differs.
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (op_q)
            2'b00: begin
                alu_res = a_q + b_shifted;
                alu_v   = (a_q[WIDTH-1] == b_shifted[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            2'b01: begin
                alu_res = a_q - b_shifted;
                alu_v   = (a_q[WIDTH-1] != b_shifted[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            2'b10: alu_res = a_q & b_shifted;
            default: alu_res = ~b_shifted;
        endcase
    end

    // Operation fields are captured only when a request is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_a_q   <= 3'd0;
            rd_b_q   <= 3'd0;
            rd_dst_q <= 3'd0;
            shift_q  <= 2'b00;
            op_q     <= 2'b00;
        end else if (state_q == S_IDLE && start) begin
            rd_a_q   <= rd_a;
            rd_b_q   <= rd_b;
            rd_dst_q <= rd_dst;
            shift_q  <= shift;
            op_q     <= alu_op;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            case (state_q)
                S_RDA: begin
                    a_q <= reg_data;
`ifdef EXEC_UNIT_SAMEREG_EN
                    if (same_src) b_q <= reg_data;
`endif
                end
                S_RDB: b_q <= reg_data;
                S_EXEC: begin
                    c_q <= alu_res;
                    z_q <= (alu_res == '0);
                    n_q <= alu_res[WIDTH-1];
                    v_q <= alu_v;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: behavioural register file, vector table and result queue.
module tb_exec_unit;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [2:0]    rd_a, rd_b, rd_dst;
    logic [1:0]    shift, alu_op;
    logic [W-1:0]  reg_data;
    logic [2:0]    readnum, writenum;
    logic          write;
    logic [W-1:0]  wb_data;
    logic          busy, done, z, n, v;

    logic [W-1:0]  rf [8];
    logic          pl_en;
    logic [2:0]    pl_addr;
    logic [W-1:0]  pl_val;

    always #5 clk = ~clk;

    exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rd_a(rd_a), .rd_b(rd_b), .rd_dst(rd_dst),
        .shift(shift), .alu_op(alu_op), .reg_data(reg_data),
        .readnum(readnum), .writenum(writenum), .write(write),
        .wb_data(wb_data), .busy(busy), .done(done),
        .z(z), .n(n), .v(v)
    );

    assign reg_data = rf[readnum];

    always @(posedge clk) begin
        if (write) rf[writenum] <= wb_data;
        else if (pl_en) rf[pl_addr] <= pl_val;
    end

    typedef struct {
        logic [2:0]   ra, rb, rd;
        logic [1:0]   sh, op;
        logic [W-1:0] va, vb, c;
        logic         ez, en, ev;
    } vec_t;

    typedef struct {
        logic [2:0]   rd;
        logic [W-1:0] c;
        logic         ez, en, ev;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk("wb_data", 32'(wb_data), 32'(e.c));
            chk("writenum", 32'(writenum), 32'(e.rd));
            chk("write", 32'(write), 32'd1);
            chk("flags_znv", {29'd0, z, n, v}, {29'd0, e.ez, e.en, e.ev});
            $display("op done: rd=%0d c=%h z=%b n=%b v=%b", writenum, wb_data, z, n, v);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [W-1:0] val);
        pl_en = 1'b1; pl_addr = a; pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic set_fields(input vec_t t);
        rd_a = t.ra; rd_b = t.rb; rd_dst = t.rd; shift = t.sh; alu_op = t.op;
    endtask

    task automatic do_op(input vec_t t);
        int lat;
        int cyc;
        bit got;
        preload(t.ra, t.va);
        preload(t.rb, t.vb);
        sbq.push_back('{t.rd, t.c, t.ez, t.en, t.ev});
        set_fields(t);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 4;
`ifdef EXEC_UNIT_SAMEREG_EN
        if (t.ra == t.rb) lat = 3;
`endif
        got = 1'b0;
        cyc = 1;
        while (!got && cyc <= 8) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("readnum_a", 32'(readnum), 32'(t.ra));
                chk("busy_rda", 32'(busy), 32'd1);
            end
            if (cyc == 2 && lat == 4) chk("readnum_b", 32'(readnum), 32'(t.rb));
            if (done) begin
                got = 1'b1;
                chk("latency", 32'(cyc), 32'(lat));
                pop_compare();
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        chk("rf_dst", 32'(rf[t.rd]), 32'(t.c));
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int first_c, second_c;
        vec_t t;

        vecs[0]  = '{3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{3'd1, 3'd2, 3'd3, 2'b00, 2'b01, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'd1, 3'd2, 3'd3, 2'b11, 2'b11, 16'h1234, 16'h8002, 16'h3FFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd1, 3'd2, 3'd3, 2'b01, 2'b10, 16'hFFFF, 16'h8002, 16'h0004, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd1, 3'd2, 3'd3, 2'b10, 2'b00, 16'h0001, 16'h8002, 16'h4002, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd1, 3'd2, 3'd3, 2'b00, 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'd4, 3'd4, 3'd5, 2'b00, 2'b00, 16'h0006, 16'h0006, 16'h000C, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd6, 3'd7, 3'd6, 2'b00, 2'b01, 16'h000A, 16'h0004, 16'h0006, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'd1, 3'd2, 3'd0, 2'b00, 2'b11, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'd1, 3'd2, 3'd3, 2'b00, 2'b10, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'd1, 3'd2, 3'd7, 2'b00, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};

        reset_n = 1'b0; start = 1'b0;
        rd_a = 3'd0; rd_b = 3'd0; rd_dst = 3'd0; shift = 2'b00; alu_op = 2'b00;
        pl_en = 1'b0; pl_addr = 3'd0; pl_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy_write_done", {29'd0, busy, write, done}, 32'd0);
        chk("reset_readnum_writenum", {26'd0, readnum, writenum}, 32'd0);
        chk("reset_wb_data", 32'(wb_data), 32'd0);
        chk("reset_flags", {29'd0, z, n, v}, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);

        for (int i = 0; i < 12; i++) do_op(vecs[i]);

        // start held for 10 edges: two operations, five cycles apart
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        t = vecs[0];
        set_fields(t);
        sbq.push_back('{t.rd, t.c, t.ez, t.en, t.ev});
        sbq.push_back('{t.rd, t.c, t.ez, t.en, t.ev});
        ndone = 0; first_c = -1; second_c = -1;
        start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (k == 9) start = 1'b0;
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) first_c = k + 1;
                else second_c = k + 1;
                pop_compare();
            end
        end
        chk("held_start_dones", 32'(ndone), 32'd2);
        chk("held_start_first", 32'(first_c), 32'd4);
        chk("held_start_gap", 32'(second_c - first_c), 32'd5);
        chk("held_start_queue_empty", 32'(sbq.size()), 32'd0);

        // start pulsed while busy must be ignored
        preload(3'd5, 16'h0055);
        preload(3'd3, 16'h0000);
        set_fields(t);
        sbq.push_back('{t.rd, t.c, t.ez, t.en, t.ev});
        ndone = 0;
        start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
            if (k == 1) begin start = 1'b1; rd_dst = 3'd5; alu_op = 2'b11; end
            if (k == 2) start = 1'b0;
            @(negedge clk);
            if (done) begin
                ndone++;
                pop_compare();
            end
        end
        chk("busy_start_dones", 32'(ndone), 32'd1);
        chk("busy_start_rf3", 32'(rf[3]), 32'h0008);
        chk("busy_start_rf5_untouched", 32'(rf[5]), 32'h0055);

        // reset asserted during EXEC aborts the operation
        @(posedge clk); #1;
        preload(3'd3, 16'h00AA);
        set_fields(t);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy_write_done", {29'd0, busy, write, done}, 32'd0);
        chk("abort_readnum_writenum", {26'd0, readnum, writenum}, 32'd0);
        chk("abort_wb_data", 32'(wb_data), 32'd0);
        chk("abort_flags", {29'd0, z, n, v}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_rf3_untouched", 32'(rf[3]), 32'h00AA);
        @(posedge clk); #1;

        do_op(vecs[0]);
        chk("final_queue_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
